// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline control / exception sequencer:
// control-op codes, exception causes, control-register addresses, FSM state
// encodings and the internal event classification used by pipe_ctrl.
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

    // Control operations carried by the instruction in MEM.
    typedef enum logic [1:0] {
        CTRL_NOP  = 2'd0,
        CTRL_WRCR = 2'd1,
        CTRL_EXRT = 2'd2,
        CTRL_RSVD = 2'd3   // decoded as NOP
    } ctrl_op_e;

    // Exception causes: 0 means "no exception", 1..6 come from the ISA,
    // 7 is reserved for the external interrupt.
    localparam logic [2:0] EXP_NONE = 3'd0;
    localparam logic [2:0] EXP_IRQ  = 3'd7;

    // Control-register addresses reachable through WRCR.
    localparam logic [4:0] CREG_STATUS = 5'd0;
    localparam logic [4:0] CREG_VECTOR = 5'd3;
    localparam logic [4:0] CREG_EPC    = 5'd4;

    // Sequencer states.
    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_WAIT_BUS = 1'b1
    } state_e;

    // Event seen at MEM, already resolved by priority.
    typedef enum logic [1:0] {
        EV_NONE = 2'd0,
        EV_EXP  = 2'd1,   // ISA exception or interrupt
        EV_EXRT = 2'd2,
        EV_WRCR = 2'd3
    } event_e;

endpackage

// File: rtl/pipe_ctrl_regs.sv
// ---------------------------------------------------------------------------
// ctrl_regs
// Architectural control state owned by the exception sequencer.
//   clk, reset      : core clock, asynchronous active-high reset
//   take_exp        : exception/interrupt taken this cycle
//   take_exrt       : EXRT executed this cycle
//   take_wrcr       : WRCR executed this cycle
//   cause           : exception code to record on take_exp
//   mem_pc          : PC of the instruction in MEM
//   mem_br_flag     : MEM instruction is in a branch delay slot
//   dst_addr        : WRCR control-register address
//   wr_data         : WRCR write data
//   epc, exp_code   : saved exception PC and cause
//   int_en          : interrupt enable
//   vector          : exception vector
// ---------------------------------------------------------------------------
module ctrl_regs
    import pipe_ctrl_pkg::*;
#(
    parameter int                     WORD_ADDR_W = 30,
    parameter int                     EXP_W       = 3,
    parameter logic [WORD_ADDR_W-1:0] RST_VECTOR  = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   take_exp,
    input  logic                   take_exrt,
    input  logic                   take_wrcr,
    input  logic [EXP_W-1:0]       cause,
    input  logic [WORD_ADDR_W-1:0] mem_pc,
    input  logic                   mem_br_flag,
    input  logic [4:0]             dst_addr,
    input  logic [31:0]            wr_data,
    output logic [WORD_ADDR_W-1:0] epc,
    output logic [EXP_W-1:0]       exp_code,
    output logic                   int_en,
    output logic [WORD_ADDR_W-1:0] vector
);

    logic prev_int_en;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            epc         <= '0;
            exp_code    <= '0;
            int_en      <= 1'b0;
            prev_int_en <= 1'b0;
            vector      <= RST_VECTOR;
        end else if (take_exp) begin
            // A delay-slot instruction restarts at its branch.
            epc         <= mem_br_flag ? mem_pc - WORD_ADDR_W'(1) : mem_pc;
            exp_code    <= cause;
            prev_int_en <= int_en;
            int_en      <= 1'b0;
        end else if (take_exrt) begin
            int_en <= prev_int_en;
        end else if (take_wrcr) begin
            case (dst_addr)
                CREG_STATUS: {prev_int_en, int_en} <= wr_data[1:0];
                CREG_VECTOR: vector <= WORD_ADDR_W'(wr_data[31:2]);
                CREG_EPC:    epc    <= WORD_ADDR_W'(wr_data[31:2]);
                default:     ;
            endcase
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
// Pipeline control and exception sequencer for the 5-stage core.
//   clk, reset                  : core clock, asynchronous active-high reset
//   IFBusy, MemBusy             : bus wait from instruction / data side
//   LoadHazard                  : ID depends on a load currently in EX
//   Irq                         : external level interrupt (asynchronous)
//   MemPC/MemEn/MemBrFlag       : instruction in MEM, its valid and delay-slot flag
//   MemCtrlOp/MemDstAddr/MemOut : control op, WRCR address and data
//   MemExpCode                  : exception raised by the MEM instruction
//   *Stall / *Flush             : hold / clear the IF, ID, EX, MEM registers
//   NewPC                       : fetch redirect, valid while IFFlush=1
//   EPC, ExpCode, IntEn         : architectural exception state
// ---------------------------------------------------------------------------
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int                     WORD_ADDR_W = 30,
    parameter int                     EXP_W       = 3,
    parameter logic [WORD_ADDR_W-1:0] RST_VECTOR  = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   IFBusy,
    input  logic                   MemBusy,
    input  logic                   LoadHazard,
    input  logic                   Irq,
    input  logic [WORD_ADDR_W-1:0] MemPC,
    input  logic                   MemEn,
    input  logic                   MemBrFlag,
    input  logic [1:0]             MemCtrlOp,
    input  logic [4:0]             MemDstAddr,
    input  logic [EXP_W-1:0]       MemExpCode,
    input  logic [31:0]            MemOut,
    output logic                   IFStall,
    output logic                   IDStall,
    output logic                   EXStall,
    output logic                   MemStall,
    output logic                   IFFlush,
    output logic                   IDFlush,
    output logic                   EXFlush,
    output logic                   MemFlush,
    output logic [WORD_ADDR_W-1:0] NewPC,
    output logic [WORD_ADDR_W-1:0] EPC,
    output logic [EXP_W-1:0]       ExpCode,
    output logic                   IntEn
);

    state_e                 state_q, state_d;
    logic                   irq_meta, irq_sync;
    logic                   irq_req;
    logic                   busy;
    event_e                 ev;
    logic [EXP_W-1:0]       ev_cause;
    logic                   take;
    logic [WORD_ADDR_W-1:0] vector;
    logic [3:0]             stall_v;   // {IF, ID, EX, MEM}
    logic [3:0]             flush_v;   // {IF, ID, EX, MEM}

    // Two-flop synchronizer for the asynchronous interrupt line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_meta <= 1'b0;
            irq_sync <= 1'b0;
        end else begin
            irq_meta <= Irq;
            irq_sync <= irq_meta;
        end
    end

    assign irq_req = irq_sync & IntEn;
    assign busy    = IFBusy | MemBusy;

    // Resolve the MEM-stage event by priority.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        ev       = EV_NONE;
        ev_cause = MemExpCode;
        if (MemEn) begin
            if (MemExpCode != '0) begin
                ev = EV_EXP;
            end else if (irq_req) begin
                ev       = EV_EXP;
                ev_cause = EXP_W'(EXP_IRQ);
            end else if (MemCtrlOp == CTRL_EXRT) begin
                ev = EV_EXRT;
            end else if (MemCtrlOp == CTRL_WRCR) begin
                ev = EV_WRCR;
            end
        end
    end

    // A pending event is held off while the bus is busy; the stall keeps MEM
    // intact, so it is re-evaluated and taken on the first idle cycle.
    assign take = ~busy & (ev != EV_NONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_RUN;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:      if (busy && ev != EV_NONE) state_d = ST_WAIT_BUS;
            ST_WAIT_BUS: if (!busy)                 state_d = ST_RUN;
            default:                                state_d = ST_RUN;
        endcase
    end

    // Stall / flush / redirect.
    always_comb begin
        stall_v = 4'b0000;
        flush_v = 4'b0000;
        NewPC   = '0;
        if (reset) begin
            // Held quiet while reset is asserted.
        end else if (busy) begin
            stall_v = 4'b1111;
        end else if (take) begin
            case (ev)
                EV_EXP: begin
                    flush_v = 4'b1111;
                    NewPC   = vector;
                end
                EV_EXRT: begin
                    flush_v = 4'b1111;
                    NewPC   = EPC;
                end
                EV_WRCR: begin
                    // MEM completes the write; younger stages refetch.
                    flush_v = 4'b1110;
                    NewPC   = MemPC + WORD_ADDR_W'(1);
                end
                default: ;
            endcase
        end else if (LoadHazard) begin
            // Hold IF/ID, inject a bubble into EX.
            stall_v = 4'b1100;
            flush_v = 4'b0100;
        end
    end

    assign {IFStall, IDStall, EXStall, MemStall} = stall_v;
    assign {IFFlush, IDFlush, EXFlush, MemFlush} = flush_v;

    ctrl_regs #(
        .WORD_ADDR_W (WORD_ADDR_W),
        .EXP_W       (EXP_W),
        .RST_VECTOR  (RST_VECTOR)
    ) u_ctrl_regs (
        .clk         (clk),
        .reset       (reset),
        .take_exp    (take && ev == EV_EXP),
        .take_exrt   (take && ev == EV_EXRT),
        .take_wrcr   (take && ev == EV_WRCR),
        .cause       (ev_cause),
        .mem_pc      (MemPC),
        .mem_br_flag (MemBrFlag),
        .dst_addr    (MemDstAddr),
        .wr_data     (MemOut),
        .epc         (EPC),
        .exp_code    (ExpCode),
        .int_en      (IntEn),
        .vector      (vector)
    );

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline control and exception sequencer for the 5-stage core.
- Drives Stall/Flush for the IF, ID, EX and MEM pipeline registers.
- Resolves exceptions and interrupts at the MEM stage and redirects fetch.
- Executes control ops (EXRT, WRCR) that reach MEM.
- Owns EPC, exception code, interrupt-enable state and the exception vector.

Parameters:
WORD_ADDR_W, 30, instruction/word address width
EXP_W, 3, exception code width
RST_VECTOR, 30'h0, exception vector after reset

Ports:
clk  in  1  core clock
reset  in  1  asynchronous reset, active-high
IFBusy  in  1  instruction bus wait
MemBusy  in  1  data bus wait
LoadHazard  in  1  ID needs result of a load in EX
Irq  in  1  external interrupt, level, asynchronous
MemPC  in  WORD_ADDR_W  PC of instruction in MEM
MemEn  in  1  MEM holds a valid instruction
MemBrFlag  in  1  MEM instruction sits in a branch delay slot
MemCtrlOp  in  2  0=NOP 1=WRCR 2=EXRT 3=reserved (NOP)
MemDstAddr  in  5  control-register address for WRCR
MemExpCode  in  EXP_W  exception code from MEM (0 = none)
MemOut  in  32  WRCR write data
IFStall, IDStall, EXStall, MemStall  out  1 each  hold stage register
IFFlush, IDFlush, EXFlush, MemFlush  out  1 each  clear stage register
NewPC  out  WORD_ADDR_W  redirect target, valid while IFFlush=1
EPC  out  WORD_ADDR_W  saved exception PC
ExpCode  out  EXP_W  last exception cause (0..6 ISA, 7 = IRQ)
IntEn  out  1  interrupt enable

Behaviour:
- Reset (async, immediate):
  - State=RUN, EPC=0, ExpCode=0, IntEn=0, PrevIntEn=0, Vector=RST_VECTOR, irq sync flops=0.
  - All Stall/Flush=0, NewPC=0.
- Irq path: two-flop synchronizer. IrqReq = IrqSync & IntEn.
- Busy: Busy = IFBusy | MemBusy. While Busy, all four Stall=1 and all Flush=0; no event is taken.
- Event detection, only in RUN with MemEn=1, in priority order:
  1. MemExpCode!=0
  2. IrqReq
  3. MemCtrlOp=EXRT
  4. MemCtrlOp=WRCR
- Exception/IRQ (combinational in cycle N):
  - IF/ID/EX/MemFlush=1; NewPC=Vector.
  - At end of N: EPC = MemBrFlag ? MemPC-1 : MemPC (mod 2^WORD_ADDR_W); ExpCode=cause; PrevIntEn=IntEn; IntEn=0.
- EXRT: IF/ID/EX/MemFlush=1; NewPC=EPC; at end of N IntEn=PrevIntEn.
- WRCR: IF/ID/EXFlush=1; NewPC=MemPC+1 (refetch). MEM not flushed. Register write by MemDstAddr:
  - 0: {PrevIntEn, IntEn} = MemOut[1:0]
  - 3: Vector = MemOut[31:2]
  - 4: EPC = MemOut[31:2]
  - other: ignored.
- Event while Busy: state goes RUN→WAIT_BUS; all stages stall. On the first cycle Busy=0, return to RUN and take the event in that cycle (MEM contents are unchanged by the stall).
- LoadHazard (no Busy, no event): IFStall=IDStall=1, IDFlush=1 (bubble into EX); EX and MEM advance.
- An event overrides LoadHazard in the same cycle.
- Single-cycle events: flushed MEM makes MemEn=0 next cycle, so no double-take.
- Irq deasserting before sync completes: nothing is taken.
- Outputs are combinational from state and inputs; EPC, ExpCode and IntEn are registered.

Decomposition:
- Shared header: CTRL_OP codes, ISA_EXP codes (add EXP_IRQ=7), control-register addresses (CREG_STATUS=0, CREG_VECTOR=3, CREG_EPC=4), state encodings RUN/WAIT_BUS.
- One sub-module: ctrl_regs, holding EPC, ExpCode, IntEn, PrevIntEn, Vector and WRCR decode.
- The FSM and stall/flush logic stay in pipe_ctrl.

Test Plan:
1. Reset mid-run with reset=1 pulse → IntEn=0, EPC=0, Vector=RST_VECTOR and all Stall/Flush=0 immediately, before the next clk edge.
2. MemEn=1, MemExpCode=3, MemPC=0x100, MemBrFlag=1 → same cycle all Flush=1, NewPC=Vector; next cycle EPC=0xFF, ExpCode=3, IntEn=0.
3. WRCR addr 0 data 0x1, then Irq=1 → IRQ taken 2 cycles after Irq rises at the next valid MEM instruction; ExpCode=7, PrevIntEn=1. Then EXRT → NewPC=EPC, IntEn=1.
4. MemExpCode=2 with MemBusy=1 for 3 cycles → all Stall=1 for 3 cycles, no Flush; flush and redirect in the cycle MemBusy drops.
5. LoadHazard=1 alone → IFStall=IDStall=IDFlush=1, EXStall=MemStall=0. LoadHazard=1 together with an exception → exception flush wins.
6. WRCR addr 3 data 0x400, then exception → NewPC=0x100. WRCR refetch → NewPC=MemPC+1, MemFlush=0.
